// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: drives register-file read addresses, resolves operands with
// MEM/WB bypassing, stalls on load-use hazards and holds a valid/ready payload for EX.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [4:0]        InRs1,
  input  logic [4:0]        InRs2,
  input  logic              InUseRs1,
  input  logic              InUseRs2,
  input  logic [4:0]        InRd,
  input  logic              InMemRead,
  input  logic [XLEN-1:0]   InImm,
  input  logic [CTRL_W-1:0] InCtrl,
  output logic [4:0]        ReadReg1,
  output logic [4:0]        ReadReg2,
  input  logic [XLEN-1:0]   ReadData1,
  input  logic [XLEN-1:0]   ReadData2,
  input  logic [4:0]        MemRd,
  input  logic              MemRegWrite,
  input  logic              MemIsLoad,
  input  logic [XLEN-1:0]   MemResult,
  input  logic [4:0]        WbRd,
  input  logic              WbRegWrite,
  input  logic [XLEN-1:0]   WbData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [XLEN-1:0]   OutOp1,
  output logic [XLEN-1:0]   OutOp2,
  output logic [XLEN-1:0]   OutImm,
  output logic [CTRL_W-1:0] OutCtrl,
  output logic [4:0]        OutRd,
  output logic              OutMemRead,
  output logic [4:0]        OutRs1,
  output logic [4:0]        OutRs2,
  output logic [CNT_W-1:0]  StallCount
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   op1_q, op2_q, op1_d, op2_d;
  logic [XLEN-1:0]   imm_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic              memread_q;
  logic [CNT_W-1:0]  stall_q;
  logic              hazard, accept, hold, stalled;

  // Bypass priority: x0, then a non-load MEM result, then the same-cycle WB write,
  // then the register file (which does not yet see the WB write this cycle).
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rdata,
    input logic [4:0]      mem_rd,
    input logic            mem_we,
    input logic            mem_ld,
    input logic [XLEN-1:0] mem_res,
    input logic [4:0]      wb_rd,
    input logic            wb_we,
    input logic [XLEN-1:0] wb_dat
  );
    if (rs == 5'd0)                               return '0;
    else if (mem_we && !mem_ld && mem_rd == rs)   return mem_res;
    else if (wb_we && wb_rd == rs)                return wb_dat;
    else                                          return rdata;
  endfunction

  // True when the incoming instruction actually reads register r.
  function automatic logic dep(input logic [4:0] r);
    return (InUseRs1 && InRs1 == r) || (InUseRs2 && InRs2 == r);
  endfunction

  assign ReadReg1 = InRs1;
  assign ReadReg2 = InRs2;

  // Operand resolution and load-use hazard detection for the incoming instruction.
  always_comb begin
    op1_d  = sel_operand(InRs1, ReadData1, MemRd, MemRegWrite, MemIsLoad, MemResult,
                         WbRd, WbRegWrite, WbData);
    op2_d  = sel_operand(InRs2, ReadData2, MemRd, MemRegWrite, MemIsLoad, MemResult,
                         WbRd, WbRegWrite, WbData);
    hazard = InValid &&
             ((valid_q && memread_q && rd_q != 5'd0 && dep(rd_q)) ||
              (MemRegWrite && MemIsLoad && MemRd != 5'd0 && dep(MemRd)));
  end

  assign InReady = !hazard && (!valid_q || OutReady) && !Flush;
  assign accept  = InValid && InReady;
  assign hold    = valid_q && !OutReady;
  assign stalled = InValid && !InReady;

  // Valid next-state: flush kills, acceptance fills, consumption or empty drains.
  always_comb begin
    valid_d = valid_q;
    if (Flush)                      valid_d = 1'b0;
    else if (accept)                valid_d = 1'b1;
    else if (OutReady || !valid_q)  valid_d = 1'b0;
  end

  // Valid register; reset drops any entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // Payload register: load on accept, otherwise snoop WB into a held entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q     <= '0;
      op2_q     <= '0;
      imm_q     <= '0;
      ctrl_q    <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      memread_q <= 1'b0;
    end else if (accept) begin
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      imm_q     <= InImm;
      ctrl_q    <= InCtrl;
      rd_q      <= InRd;
      rs1_q     <= InRs1;
      rs2_q     <= InRs2;
      memread_q <= InMemRead;
    end else if (hold) begin
      if (WbRegWrite && WbRd != 5'd0 && WbRd == rs1_q) op1_q <= WbData;
      if (WbRegWrite && WbRd != 5'd0 && WbRd == rs2_q) op2_q <= WbData;
    end
  end

  // Saturating count of cycles where decode had an instruction but was refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            stall_q <= '0;
    else if (stalled && stall_q != '1)     stall_q <= stall_q + 1'b1;
  end

  assign OutValid   = valid_q;
  assign OutOp1     = op1_q;
  assign OutOp2     = op2_q;
  assign OutImm     = imm_q;
  assign OutCtrl    = ctrl_q;
  assign OutRd      = rd_q;
  assign OutMemRead = memread_q;
  assign OutRs1     = rs1_q;
  assign OutRs2     = rs2_q;
  assign StallCount = stall_q;

endmodule
